// File: rtl/axis_demux_1to2.sv
// axis_demux_1to2: packet-aware 1:2 AXI-Stream demultiplexer.
//
// Each packet from the slave stream goes to port 1 (sel=0) or port 2 (sel=1). The
// destination is sampled on the first beat and locked until the beat carrying last has
// been accepted, so a packet is never split across outputs. Each master port has a
// single register stage that sustains one beat per cycle.
//
// Note: reset_n keeps its historical name but is synchronous and ACTIVE-HIGH.
//
// Optional feature macro: AXIS_DEMUX_PKT_COUNT_EN
//   When defined, adds pkt_count_1 / pkt_count_2, 16-bit wrapping counts of output
//   handshakes that carry last. When undefined, those ports and counters are absent.
module axis_demux_1to2 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data_1,
    output logic                  m_axis_valid_1,
    input  logic                  m_axis_ready_1,
    output logic                  m_axis_last_1,
    output logic [DATA_WIDTH-1:0] m_axis_data_2,
    output logic                  m_axis_valid_2,
    input  logic                  m_axis_ready_2,
    output logic                  m_axis_last_2,
    input  logic                  sel
`ifdef AXIS_DEMUX_PKT_COUNT_EN
    ,
    output logic [15:0]           pkt_count_1,
    output logic [15:0]           pkt_count_2
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPkt1 = 2'd1,
        StPkt2 = 2'd2
    } state_e;

    state_e state_q, state_d;

    // dst: 0 = port 1, 1 = port 2
    logic dst;
    logic accept;
    logic free_1, free_2;

    logic                  valid_1_q, valid_1_d;
    logic [DATA_WIDTH-1:0] data_1_q, data_1_d;
    logic                  last_1_q, last_1_d;
    logic                  valid_2_q, valid_2_d;
    logic [DATA_WIDTH-1:0] data_2_q, data_2_d;
    logic                  last_2_q, last_2_d;

    // Destination: live sel between packets, locked while a packet is in progress.
    // The unused encoding behaves like idle so a corrupted state self-recovers.
    always_comb begin
        dst = sel;
        case (state_q)
            StIdle:  dst = sel;
            StPkt1:  dst = 1'b0;
            StPkt2:  dst = 1'b1;
            default: dst = sel;
        endcase
    end

    // Upstream ready depends only on the chosen register being free, never on s_axis_valid.
    always_comb begin
        free_1       = !valid_1_q || m_axis_ready_1;
        free_2       = !valid_2_q || m_axis_ready_2;
        s_axis_ready = !reset_n && (dst ? free_2 : free_1);
        accept       = s_axis_valid && s_axis_ready;
    end

    // Next state: open a packet on a non-last first beat, close it on the last beat.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (s_axis_last) begin
                state_d = StIdle;
            end else begin
                state_d = dst ? StPkt2 : StPkt1;
            end
        end
    end

    // Port 1 register: load on an accept routed here, otherwise drain when ready.
    always_comb begin
        valid_1_d = valid_1_q;
        data_1_d  = data_1_q;
        last_1_d  = last_1_q;
        if (accept && !dst) begin
            valid_1_d = 1'b1;
            data_1_d  = s_axis_data;
            last_1_d  = s_axis_last;
        end else if (m_axis_ready_1) begin
            valid_1_d = 1'b0;
        end
    end

    // Port 2 register: same as port 1, independent of it.
    always_comb begin
        valid_2_d = valid_2_q;
        data_2_d  = data_2_q;
        last_2_d  = last_2_q;
        if (accept && dst) begin
            valid_2_d = 1'b1;
            data_2_d  = s_axis_data;
            last_2_d  = s_axis_last;
        end else if (m_axis_ready_2) begin
            valid_2_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q   <= StIdle;
            valid_1_q <= 1'b0;
            data_1_q  <= '0;
            last_1_q  <= 1'b0;
            valid_2_q <= 1'b0;
            data_2_q  <= '0;
            last_2_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_1_q <= valid_1_d;
            data_1_q  <= data_1_d;
            last_1_q  <= last_1_d;
            valid_2_q <= valid_2_d;
            data_2_q  <= data_2_d;
            last_2_q  <= last_2_d;
        end
    end

    assign m_axis_valid_1 = valid_1_q;
    assign m_axis_data_1  = data_1_q;
    assign m_axis_last_1  = last_1_q;
    assign m_axis_valid_2 = valid_2_q;
    assign m_axis_data_2  = data_2_q;
    assign m_axis_last_2  = last_2_q;

`ifdef AXIS_DEMUX_PKT_COUNT_EN
    logic [15:0] cnt_1_q, cnt_1_d;
    logic [15:0] cnt_2_q, cnt_2_d;

    // Count completed packets as seen downstream; 16-bit counters wrap naturally.
    always_comb begin
        cnt_1_d = cnt_1_q;
        cnt_2_d = cnt_2_q;
        if (valid_1_q && m_axis_ready_1 && last_1_q) begin
            cnt_1_d = cnt_1_q + 16'd1;
        end
        if (valid_2_q && m_axis_ready_2 && last_2_q) begin
            cnt_2_d = cnt_2_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt_1_q <= '0;
            cnt_2_q <= '0;
        end else begin
            cnt_1_q <= cnt_1_d;
            cnt_2_q <= cnt_2_d;
        end
    end

    assign pkt_count_1 = cnt_1_q;
    assign pkt_count_2 = cnt_2_q;
`endif

endmodule

// File: doc/axis_demux_1to2.md
# axis_demux_1to2

Packet-aware 1:2 AXI-Stream demultiplexer, the split-side counterpart of the 2:1 stream mux. It routes each packet from one slave stream to one of two master streams, chosen by `sel`. The destination is locked for the whole packet, so a packet is never split across outputs. Each output has a one-entry register stage that runs at full throughput. It sits between a single upstream producer and two independent downstream consumers.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: tdata width of all streams.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-high reset. The port keeps the codebase name; high = reset.
- `s_axis_data`  in  DATA_WIDTH  input tdata.
- `s_axis_valid`  in  1  input tvalid.
- `s_axis_ready`  out  1  input tready.
- `s_axis_last`  in  1  input tlast.
- `m_axis_data_1` / `m_axis_data_2`  out  DATA_WIDTH  output tdata, port 1 / port 2.
- `m_axis_valid_1` / `m_axis_valid_2`  out  1  output tvalid.
- `m_axis_ready_1` / `m_axis_ready_2`  in  1  output tready.
- `m_axis_last_1` / `m_axis_last_2`  out  1  output tlast.
- `sel`  in  1  destination request: 0 = port 1, 1 = port 2. Sampled only at packet start.
- `pkt_count_1` / `pkt_count_2`  out  16  completed-packet counters. Present only with `AXIS_DEMUX_PKT_COUNT_EN`.

## Operation
State machine, 2-bit state:
- `IDLE`: no packet in progress. The active destination `dst` is the live `sel`.
- `PKT_1` / `PKT_2`: packet in progress. `dst` is locked to port 1 / port 2; `sel` is ignored.

Input acceptance:
- Accept = `s_axis_valid && s_axis_ready`.
- `IDLE`, accept with last=0 → `PKT_1` if `sel`=0, `PKT_2` if `sel`=1.
- `IDLE`, accept with last=1 → stays `IDLE`. This is a single-beat packet, routed by the current `sel`.
- `PKT_x`, accept with last=1 → `IDLE`. Any other accept → stay in `PKT_x`.

Output stage, per port p:
- Register {valid_p, data_p, last_p}.
- The register is free when `!valid_p || m_axis_ready_p`.
- On an accept with `dst`=p: load data/last and set valid_p=1.
- Otherwise, if `m_axis_ready_p`: clear valid_p to 0.
- data/last hold their value while valid_p=0.

`s_axis_ready`:
- Equals 0 while `reset_n`=1.
- Otherwise equals "register of `dst` is free".
- It is combinational from `m_axis_ready_dst`, `valid_dst`, state and `sel`. There is no combinational path from `s_axis_valid`.

Port independence: the non-selected port keeps draining its held beat. A switch of `dst` never stalls on, or corrupts, the other port.

Protocol rules:
- A master's data/last are stable while valid=1 and ready=0.
- Beats are never dropped, duplicated or reordered.

## Timing
- Reset values: `m_axis_valid_*`=0, `m_axis_data_*`=0, `m_axis_last_*`=0, state=`IDLE`, counters=0, `s_axis_ready`=0 during reset.
- First cycle after reset release: `s_axis_ready`=1.
- Latency: a beat accepted at edge N is visible on `m_axis_*_p` at edge N.
- Throughput: 1 beat/cycle sustained when the destination ready is held at 1.
- Backpressure: `m_axis_ready_dst`=0 with valid_dst=1 forces `s_axis_ready`=0 in the same cycle.
- Simultaneous events in one cycle: port p drains (valid_p && ready_p) and accepts a new beat for p. The register reloads and valid_p stays 1.
- `sel` toggling mid-packet has no effect. A `sel` change in `IDLE` applies to that cycle's acceptance.
- Reset mid-packet:
  - state returns to `IDLE`;
  - held output beats are discarded (valid=0);
  - counters clear;
  - no partial-packet recovery.

## Configuration
- `AXIS_DEMUX_PKT_COUNT_EN` defined:
  - `pkt_count_1` and `pkt_count_2` ports exist.
  - Each increments by 1 on every output handshake of port p with `m_axis_last_p`=1.
  - Counters wrap 0xFFFF → 0x0000.
  - Reset value is 0.
- Undefined: the counter ports and logic are absent. Datapath behaviour is identical.

## Test plan
- Reset, then `sel`=0, 4-beat packet 0x11..0x14 (last on 0x14), both readies=1 → port 1 emits 0x11..0x14 on 4 consecutive cycles, last on 0x14. Port 2 valid stays 0. `pkt_count_1`=1.
- `sel` toggles every cycle during a 3-beat packet started with `sel`=1 → all 3 beats on port 2. The next packet, started with `sel`=0, goes to port 1.
- Port 1 ready=0 for 5 cycles mid-packet → `s_axis_ready`=0 from the cycle port 1 is held full. Data held stable; no loss after ready returns; exact beat order preserved.
- Single-beat packets alternating `sel` 0,1,0,1 with values 0xA0..0xA3 → 0xA0 and 0xA2 on port 1, 0xA1 and 0xA3 on port 2, each with last=1. Back-to-back, no bubbles.
- Port 2 stalled holding a beat while a new packet goes to port 1 → port 1 streams at full rate. The port 2 beat remains valid and unchanged.
- `reset_n` pulsed mid-packet → all valids 0 next cycle and counters 0. A following packet with `sel`=1 is routed to port 2 from its first beat.
